// File: rtl/memory_access_pkg.sv
// Shared types and widths for the memory-access stage: access widths, bus FSM states
// and the writeback pipeline record.
package memory_access_pkg;

    localparam int BYTE_W = 8;
    localparam int HALF_W = 16;
    localparam int WORD_W = 32;
    localparam int LANES  = WORD_W / BYTE_W;
    localparam int OFF_W  = 2;

    typedef enum logic [1:0] {
        MAW_BYTE    = 2'b00,
        MAW_HALF    = 2'b01,
        MAW_WORD    = 2'b10,
        MAW_ILLEGAL = 2'b11
    } MemAccessWidth;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } MemBusState;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic [4:0]        rd_addr;
        logic              w_enable;
        logic [WORD_W-1:0] data;
    } WritebackStagePipeReg;

endpackage

// File: rtl/memory_access_load_store_align.sv
// Combinational lane logic: misalignment detection, store strobe/data replication,
// and load lane extraction with sign/zero extension.
module load_store_align
    import memory_access_pkg::*;
(
    input  logic [OFF_W-1:0]  st_off_i,
    input  MemAccessWidth     st_width_i,
    input  logic [WORD_W-1:0] st_data_i,
    output logic              misaligned_o,
    output logic [LANES-1:0]  wstrb_o,
    output logic [WORD_W-1:0] wdata_o,
    input  logic [OFF_W-1:0]  ld_off_i,
    input  MemAccessWidth     ld_width_i,
    input  logic              ld_unsigned_i,
    input  logic [WORD_W-1:0] rdata_i,
    output logic [WORD_W-1:0] ld_data_o
);

    logic [BYTE_W-1:0] byte_lane;
    logic [HALF_W-1:0] half_lane;

    always_comb begin
        misaligned_o = (st_width_i == MAW_ILLEGAL)
                    || (st_width_i == MAW_HALF && st_off_i[0])
                    || (st_width_i == MAW_WORD && st_off_i != 2'b00);
        case (st_width_i)
            MAW_BYTE: begin
                wstrb_o = 4'b0001 << st_off_i;
                wdata_o = {4{st_data_i[BYTE_W-1:0]}};
            end
            MAW_HALF: begin
                wstrb_o = 4'b0011 << st_off_i;
                wdata_o = {2{st_data_i[HALF_W-1:0]}};
            end
            default: begin
                wstrb_o = 4'b1111;
                wdata_o = st_data_i;
            end
        endcase
    end

    always_comb begin
        byte_lane = rdata_i[BYTE_W*ld_off_i +: BYTE_W];
        half_lane = rdata_i[HALF_W*ld_off_i[1] +: HALF_W];
        case (ld_width_i)
            MAW_BYTE:
                ld_data_o = ld_unsigned_i ? {{(WORD_W-BYTE_W){1'b0}}, byte_lane}
                                          : {{(WORD_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
            MAW_HALF:
                ld_data_o = ld_unsigned_i ? {{(WORD_W-HALF_W){1'b0}}, half_lane}
                                          : {{(WORD_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
            default:
                ld_data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: issues req/ack data-memory transactions, stalls upstream
// while one is outstanding, and emits one writeback record per retired instruction.
module memory_access
    import memory_access_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
)
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_w_data,
    input  logic [1:0]  ex_mem_access_width,
    input  logic [4:0]  ex_rd_addr,
    input  logic        ex_w_enable,
    input  logic        ex_is_store,
    input  logic        ex_is_load,
    input  logic        ex_is_load_unsigned,
    output logic        stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [4:0]  wb_rd_addr,
    output logic        wb_w_enable,
    output logic [31:0] wb_data,
    output logic        exc_misaligned,
    output logic        exc_bus_error
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit          TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = TIMEOUT_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    MemBusState           state_q;
    logic [CNT_W-1:0]     tmo_cnt_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic [WORD_W-1:0]    dmem_addr_q;
    logic [LANES-1:0]     dmem_wstrb_q;
    logic [WORD_W-1:0]    dmem_wdata_q;
    logic                 wb_valid_q;
    WritebackStagePipeReg wb_q;
    logic                 exc_mis_q;
    logic                 exc_bus_q;

    // Instruction parked while its bus transaction is outstanding
    WritebackStagePipeReg pend_q;
    MemAccessWidth        pend_width_q;
    logic [OFF_W-1:0]     pend_off_q;
    logic                 pend_unsigned_q;
    logic                 pend_store_q;

    logic              ex_mem;
    logic              misaligned;
    logic [LANES-1:0]  st_wstrb;
    logic [WORD_W-1:0] st_wdata;
    logic [WORD_W-1:0] ld_data;
    logic              timeout_hit;

    assign ex_mem      = ex_is_store | ex_is_load;
    assign timeout_hit = TIMEOUT_EN && (tmo_cnt_q == CNT_LAST);

    load_store_align u_align (
        .st_off_i      (ex_alu_result[OFF_W-1:0]),
        .st_width_i    (MemAccessWidth'(ex_mem_access_width)),
        .st_data_i     (ex_w_data),
        .misaligned_o  (misaligned),
        .wstrb_o       (st_wstrb),
        .wdata_o       (st_wdata),
        .ld_off_i      (pend_off_q),
        .ld_width_i    (pend_width_q),
        .ld_unsigned_i (pend_unsigned_q),
        .rdata_i       (dmem_rdata),
        .ld_data_o     (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= IDLE;
            tmo_cnt_q       <= '0;
            dmem_req_q      <= 1'b0;
            dmem_we_q       <= 1'b0;
            dmem_addr_q     <= '0;
            dmem_wstrb_q    <= '0;
            dmem_wdata_q    <= '0;
            wb_valid_q      <= 1'b0;
            wb_q            <= '0;
            exc_mis_q       <= 1'b0;
            exc_bus_q       <= 1'b0;
            pend_q          <= '0;
            pend_width_q    <= MAW_BYTE;
            pend_off_q      <= '0;
            pend_unsigned_q <= 1'b0;
            pend_store_q    <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            exc_mis_q  <= 1'b0;
            exc_bus_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ex_valid) begin
                        if (!ex_mem) begin
                            wb_valid_q <= 1'b1;
                            wb_q <= '{pc: ex_pc, rd_addr: ex_rd_addr,
                                      w_enable: ex_w_enable, data: ex_alu_result};
                        end else if (misaligned) begin
                            wb_valid_q <= 1'b1;
                            exc_mis_q  <= 1'b1;
                            wb_q <= '{pc: ex_pc, rd_addr: ex_rd_addr,
                                      w_enable: 1'b0, data: ex_alu_result};
                        end else begin
                            state_q         <= BUSY;
                            tmo_cnt_q       <= '0;
                            dmem_req_q      <= 1'b1;
                            dmem_we_q       <= ex_is_store;
                            dmem_addr_q     <= {ex_alu_result[WORD_W-1:OFF_W], {OFF_W{1'b0}}};
                            dmem_wstrb_q    <= ex_is_store ? st_wstrb : '0;
                            dmem_wdata_q    <= ex_is_store ? st_wdata : '0;
                            pend_q <= '{pc: ex_pc, rd_addr: ex_rd_addr,
                                        w_enable: ex_w_enable, data: ex_alu_result};
                            pend_width_q    <= MemAccessWidth'(ex_mem_access_width);
                            pend_off_q      <= ex_alu_result[OFF_W-1:0];
                            pend_unsigned_q <= ex_is_load_unsigned;
                            pend_store_q    <= ex_is_store;
                        end
                    end
                end
                BUSY: begin
                    // Ack takes priority over a timeout landing in the same cycle
                    if (dmem_ack) begin
                        state_q     <= IDLE;
                        dmem_req_q  <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        wb_q.pc       <= pend_q.pc;
                        wb_q.rd_addr  <= pend_q.rd_addr;
                        wb_q.w_enable <= pend_store_q ? 1'b0 : pend_q.w_enable;
                        wb_q.data     <= pend_store_q ? pend_q.data : ld_data;
                    end else if (timeout_hit) begin
                        state_q     <= IDLE;
                        dmem_req_q  <= 1'b0;
                        wb_valid_q  <= 1'b1;
                        exc_bus_q   <= 1'b1;
                        wb_q.pc       <= pend_q.pc;
                        wb_q.rd_addr  <= pend_q.rd_addr;
                        wb_q.w_enable <= 1'b0;
                        wb_q.data     <= pend_q.data;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign stall          = (state_q != IDLE);
    assign dmem_req       = dmem_req_q;
    assign dmem_we        = dmem_we_q;
    assign dmem_addr      = dmem_addr_q;
    assign dmem_wstrb     = dmem_wstrb_q;
    assign dmem_wdata     = dmem_wdata_q;
    assign wb_valid       = wb_valid_q;
    assign wb_pc          = wb_q.pc;
    assign wb_rd_addr     = wb_q.rd_addr;
    assign wb_w_enable    = wb_q.w_enable;
    assign wb_data        = wb_q.data;
    assign exc_misaligned = exc_mis_q;
    assign exc_bus_error  = exc_bus_q;

endmodule
